// File: rtl/regfile_pkg.sv
// regfile_pkg: shared FSM encoding and default datapath widths for the register file
package regfile_pkg;
    typedef enum logic {ST_IDLE = 1'b0, ST_CLEAR = 1'b1} state_t;
    localparam int RF_DATA_W = 8;
    localparam int RF_ADDR_W = 4;
endpackage

// File: rtl/regfile_rd_port.sv
// regfile_rd_port: one read port with zero-register masking, write bypass and busy lookup
module regfile_rd_port #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 4,
    parameter int ZERO_REG = 0,
    parameter int BYPASS   = 1
) (
    input  logic [2**ADDR_W-1:0][DATA_W-1:0] regs,
    input  logic [2**ADDR_W-1:0]             busy_vec,
    input  logic                             fwd_en,
    input  logic [ADDR_W-1:0]                wr_addr,
    input  logic [DATA_W-1:0]                wr_data,
    input  logic [ADDR_W-1:0]                addr,
    output logic [DATA_W-1:0]                data,
    output logic                             busy
);
    logic zero, hit;
    assign zero = (ZERO_REG != 0) && addr == '0;
    assign hit  = (BYPASS != 0) && fwd_en && wr_addr == addr && !zero;
    assign data = zero ? '0 : hit ? wr_data : regs[addr];
    assign busy = !zero && !hit && busy_vec[addr];
endmodule

// File: rtl/regfile_bypass_sb.sv
// regfile_bypass_sb: 2R/1W register file with bypass, busy scoreboard and sequential bulk clear
module regfile_bypass_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int ZERO_REG = 0,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_addr,
    output logic              busy_a,
    output logic              busy_b,
    input  logic              clr_req,
    output logic              clr_busy
);
    localparam int DEPTH = 2**ADDR_W;
    state_t                         state;
    logic [ADDR_W-1:0]              cnt;
    logic [DEPTH-1:0][DATA_W-1:0]   regs;
    logic [DEPTH-1:0]               busy, busy_nxt;
    logic                           idle, wr_ok;
    assign idle     = state == ST_IDLE;
    assign clr_busy = state == ST_CLEAR;
    assign wr_ok    = wr_en && !((ZERO_REG != 0) && wr_addr == '0);
    // reserve is applied after release so a same-cycle reserve keeps the entry busy
    always_comb begin
        busy_nxt = busy;
        if (wr_en) busy_nxt[wr_addr] = 1'b0;
        if (rsv_en) busy_nxt[rsv_addr] = 1'b1;
        if (ZERO_REG != 0) busy_nxt[0] = 1'b0;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
            regs  <= '0;
            busy  <= '0;
        end else if (idle) begin
            if (clr_req) begin
                state <= ST_CLEAR;
                cnt   <= '0;
                busy  <= '0;
            end else begin
                busy <= busy_nxt;
                if (wr_ok) regs[wr_addr] <= wr_data;
            end
        end else begin
            regs[cnt] <= '0;
            cnt       <= cnt + ADDR_W'(1);
            if (&cnt) state <= ST_IDLE;
        end
    end
    regfile_rd_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)) u_port_a (
        .regs(regs), .busy_vec(busy), .fwd_en(wr_en && idle), .wr_addr(wr_addr), .wr_data(wr_data),
        .addr(rd_addr_a), .data(rd_data_a), .busy(busy_a)
    );
    regfile_rd_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)) u_port_b (
        .regs(regs), .busy_vec(busy), .fwd_en(wr_en && idle), .wr_addr(wr_addr), .wr_data(wr_data),
        .addr(rd_addr_b), .data(rd_data_b), .busy(busy_b)
    );
endmodule

// File: tb/tb_regfile_bypass_sb.sv
// tb_regfile_bypass_sb: directed table plus clear/reset sequences on default, zero-reg and no-bypass builds
module tb_regfile_bypass_sb;
    logic       clk = 0, rst = 1;
    logic       wr_en = 0, rsv_en = 0, clr_req = 0;
    logic [3:0] wr_addr = 0, rsv_addr = 0, rd_addr_a = 0, rd_addr_b = 0;
    logic [7:0] wr_data = 0;
    logic [7:0] da0, db0, daz, dbz, dan, dbn;
    logic       ba0, bb0, baz, bbz, ban, bbn, cb0, cbz, cbn;
    int checks = 0, failures = 0;

    always #5 clk = ~clk;

    regfile_bypass_sb u0 (.clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .rd_data_a(da0), .rd_data_b(db0), .rsv_en(rsv_en),
        .rsv_addr(rsv_addr), .busy_a(ba0), .busy_b(bb0), .clr_req(clr_req), .clr_busy(cb0));
    regfile_bypass_sb #(.ZERO_REG(1)) uz (.clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .rd_data_a(daz), .rd_data_b(dbz), .rsv_en(rsv_en),
        .rsv_addr(rsv_addr), .busy_a(baz), .busy_b(bbz), .clr_req(clr_req), .clr_busy(cbz));
    regfile_bypass_sb #(.BYPASS(0)) un (.clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .rd_data_a(dan), .rd_data_b(dbn), .rsv_en(rsv_en),
        .rsv_addr(rsv_addr), .busy_a(ban), .busy_b(bbn), .clr_req(clr_req), .clr_busy(cbn));

    typedef struct {
        logic       we;
        logic [3:0] wa;
        logic [7:0] wd;
        logic       re;
        logic [3:0] ra, aa, ab;
        logic [7:0] ea, eb;
        logic       eba, ebb;
        logic [7:0] ena;
    } vec_t;
    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic half();
        @(negedge clk);
    endtask

    task automatic pulse_rst();
        rst = 1;
        #1;
        chk("clr_busy_async_drop", {31'b0, cb0}, 0);
        #2;
        rst = 0;
    endtask

    initial begin
        // {we, wa, wd, re, ra, rd_a, rd_b, exp_a, exp_b, busy_a, busy_b, no-bypass exp_a}
        vecs[0]  = '{1, 3,  8'hA5, 0, 0, 3, 15, 8'hA5, 8'h00, 0, 0, 8'h00};
        vecs[1]  = '{1, 15, 8'h3C, 0, 0, 3, 15, 8'hA5, 8'h3C, 0, 0, 8'hA5};
        vecs[2]  = '{0, 0,  8'h00, 0, 0, 3, 15, 8'hA5, 8'h3C, 0, 0, 8'hA5};
        vecs[3]  = '{1, 5,  8'h11, 0, 0, 5, 3,  8'h11, 8'hA5, 0, 0, 8'h00};
        vecs[4]  = '{1, 5,  8'h77, 0, 0, 5, 5,  8'h77, 8'h77, 0, 0, 8'h11};
        vecs[5]  = '{0, 0,  8'h00, 1, 7, 5, 7,  8'h77, 8'h00, 0, 0, 8'h77};
        vecs[6]  = '{0, 0,  8'h00, 0, 0, 7, 3,  8'h00, 8'hA5, 1, 0, 8'h00};
        vecs[7]  = '{1, 7,  8'h99, 1, 7, 7, 7,  8'h99, 8'h99, 0, 0, 8'h00};
        vecs[8]  = '{0, 0,  8'h00, 0, 0, 7, 7,  8'h99, 8'h99, 1, 1, 8'h99};
        vecs[9]  = '{1, 7,  8'h42, 0, 0, 7, 3,  8'h42, 8'hA5, 0, 0, 8'h99};
        vecs[10] = '{0, 0,  8'h00, 0, 0, 7, 5,  8'h42, 8'h77, 0, 0, 8'h42};

        #12 rst = 0;
        half();
        chk("reset_rd_a", da0, 0);
        chk("reset_busy_a", {31'b0, ba0}, 0);
        chk("reset_clr_busy", {31'b0, cb0}, 0);
        tick();

        foreach (vecs[i]) begin
            wr_en = vecs[i].we; wr_addr = vecs[i].wa; wr_data = vecs[i].wd;
            rsv_en = vecs[i].re; rsv_addr = vecs[i].ra;
            rd_addr_a = vecs[i].aa; rd_addr_b = vecs[i].ab;
            half();
            chk($sformatf("vec%0d_rd_a", i), da0, vecs[i].ea);
            chk($sformatf("vec%0d_rd_b", i), db0, vecs[i].eb);
            chk($sformatf("vec%0d_busy_a", i), {31'b0, ba0}, {31'b0, vecs[i].eba});
            chk($sformatf("vec%0d_busy_b", i), {31'b0, bb0}, {31'b0, vecs[i].ebb});
            chk($sformatf("vec%0d_nobyp_a", i), dan, vecs[i].ena);
            tick();
        end
        wr_en = 0; rsv_en = 0;

        pulse_rst();
        rd_addr_a = 3; rd_addr_b = 15;
        half();
        chk("midrun_reset_a", da0, 0);
        chk("midrun_reset_b", db0, 0);
        tick();

        wr_en = 1; wr_addr = 0; wr_data = 8'hFF; rd_addr_a = 0; rd_addr_b = 0;
        half();
        chk("zero_bypass_masked", daz, 0);
        chk("nonzero_bypass_r0", da0, 8'hFF);
        tick();
        wr_en = 0; rsv_en = 1; rsv_addr = 0;
        half();
        chk("zero_read_r0", daz, 0);
        chk("nonzero_read_r0", da0, 8'hFF);
        tick();
        rsv_en = 0;
        half();
        chk("zero_rsv_ignored", {31'b0, baz}, 0);
        chk("nonzero_rsv_r0", {31'b0, ba0}, 1);
        tick();

        for (int i = 0; i < 16; i++) begin
            wr_en = 1; wr_addr = 4'(i); wr_data = 8'hFF;
            tick();
        end
        rsv_en = 1; rsv_addr = 9;
        tick();
        rsv_en = 0;
        clr_req = 1; wr_en = 1; wr_addr = 2; wr_data = 8'h55;
        tick();
        clr_req = 0; rsv_en = 1; rsv_addr = 15;
        for (int i = 0; i < 16; i++) begin
            half();
            chk($sformatf("clr_busy_cycle%0d", i), {31'b0, cb0}, 1);
            if (i == 10) begin
                rd_addr_a = 15; rd_addr_b = 2;
                #1;
                chk("clr_mid_r15", da0, 8'hFF);
                chk("clr_mid_r2", db0, 0);
                chk("clr_mid_busy", {31'b0, ba0}, 0);
            end
            tick();
        end
        wr_en = 0; rsv_en = 0;
        half();
        chk("clr_done", {31'b0, cb0}, 0);
        for (int i = 0; i < 16; i++) begin
            rd_addr_a = 4'(i); rd_addr_b = 4'(15 - i);
            #1;
            chk($sformatf("post_clr_r%0d", i), {da0, db0}, 0);
        end
        rd_addr_a = 9; rd_addr_b = 15;
        #1;
        chk("post_clr_busy", {30'b0, ba0, bb0}, 0);
        tick();

        clr_req = 1;
        tick();
        clr_req = 0;
        for (int i = 0; i < 5; i++) tick();
        chk("clr_before_rst", {31'b0, cb0}, 1);
        pulse_rst();
        tick();
        wr_en = 1; wr_addr = 1; wr_data = 8'h42;
        tick();
        wr_en = 0; rd_addr_a = 1;
        half();
        chk("after_rst_idle", {31'b0, cb0}, 0);
        chk("after_rst_r1", da0, 8'h42);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
